axi_wr_burst_sched: RTL and testbench

//  Write-address scheduler for the AXI4-full master port. Accepts one write command
//  (start address, total beat count) and splits it into INCR bursts on the AW channel.

---
 rtl/axi_wr_burst_sched_if.sv | 29 ++
 rtl/axi_wr_burst_sched.sv | 130 +++++++++++++
 tb/tb_axi_wr_burst_sched.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/axi_wr_burst_sched_if.sv
// rtl/axi_wr_burst_sched_if.sv - AXI4 write address/response channels of the burst scheduler

interface axi_wr_burst_sched_if #(
    parameter int ADDR_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0] m00_axi_awaddr;
    logic [7:0]            m00_axi_awlen;
    logic [2:0]            m00_axi_awsize;
    logic [1:0]            m00_axi_awburst;
    logic                  m00_axi_awvalid;
    logic                  m00_axi_awready;
    logic [1:0]            m00_axi_bresp;
    logic                  m00_axi_bvalid;
    logic                  m00_axi_bready;

    modport master (
        output m00_axi_awaddr, m00_axi_awlen, m00_axi_awsize, m00_axi_awburst, m00_axi_awvalid,
        input  m00_axi_awready,
        input  m00_axi_bresp, m00_axi_bvalid,
        output m00_axi_bready
    );

    modport slave (
        input  m00_axi_awaddr, m00_axi_awlen, m00_axi_awsize, m00_axi_awburst, m00_axi_awvalid,
        output m00_axi_awready,
        output m00_axi_bresp, m00_axi_bvalid,
        input  m00_axi_bready
    );
endinterface

// File: rtl/axi_wr_burst_sched.sv
// rtl/axi_wr_burst_sched.sv - splits one write command into 4 KB-safe INCR bursts and tracks B responses

module axi_wr_burst_sched #(
    parameter int C_AXI_ADDR_WIDTH  = 32,
    parameter int C_AXI_DATA_WIDTH  = 32,
    parameter int C_AXI_BURST_LEN   = 16,
    parameter int C_MAX_OUTSTANDING = 4
) (
    input  logic                        m00_axi_aclk,
    input  logic                        m00_axi_aresetn,
    input  logic                        cmd_valid,
    output logic                        cmd_ready,
    input  logic [C_AXI_ADDR_WIDTH-1:0] cmd_addr,
    input  logic [15:0]                 cmd_beats,
    output logic                        busy,
    output logic                        done,
    output logic                        err,
    output logic                        bst_issue,
    output logic [7:0]                  bst_len,
    axi_wr_burst_sched_if.master        m00_axi
);
    localparam int                        BYTES     = C_AXI_DATA_WIDTH / 8;
    localparam int                        SZ        = $clog2(BYTES);
    localparam logic [C_AXI_ADDR_WIDTH-1:0] ADDR_MASK = ~C_AXI_ADDR_WIDTH'(BYTES - 1);
    localparam logic [16:0]               BURST_MAX = 17'(C_AXI_BURST_LEN);
    localparam logic [3:0]                OUT_MAX   = 4'(C_MAX_OUTSTANDING);

    typedef enum logic [2:0] {S_IDLE, S_CALC, S_ADDR, S_WAIT_B, S_DONE} state_t;

    state_t                      state, state_nxt;
    logic [C_AXI_ADDR_WIDTH-1:0] addr_q;
    logic [15:0]                 remaining;
    logic [C_AXI_ADDR_WIDTH-1:0] awaddr_q;
    logic [7:0]                  awlen_q;
    logic [8:0]                  beats_q;
    logic [3:0]                  outstanding, outstanding_nxt;
    logic                        err_q;
    logic                        live_q;

    logic        accept, aw_hs, b_hs, b_bad;
    logic [12:0] page_room, page_beats;
    logic [16:0] beats_calc;
    logic [C_AXI_ADDR_WIDTH-1:0] step;

    assign accept = cmd_valid && cmd_ready;
    assign aw_hs  = (state == S_ADDR) && m00_axi.m00_axi_awready;
    assign b_hs   = m00_axi.m00_axi_bvalid && live_q;
    assign b_bad  = b_hs && ((m00_axi.m00_axi_bresp != 2'b00) || (outstanding == 4'd0));
    assign step   = {{(C_AXI_ADDR_WIDTH-9){1'b0}}, beats_q} << SZ;

    // Burst size is the smallest of what is left, the configured cap and the room to the page end.
    always_comb begin
        page_room  = 13'd4096 - {1'b0, addr_q[11:0]};
        page_beats = page_room >> SZ;
        beats_calc = {1'b0, remaining};
        if (BURST_MAX < beats_calc) beats_calc = BURST_MAX;
        if ({4'd0, page_beats} < beats_calc) beats_calc = {4'd0, page_beats};
    end

    always_comb begin
        outstanding_nxt = outstanding;
        case ({aw_hs, b_hs})
            2'b10:   outstanding_nxt = outstanding + 4'd1;
            2'b01:   outstanding_nxt = (outstanding == 4'd0) ? 4'd0 : outstanding - 4'd1;
            default: outstanding_nxt = outstanding;
        endcase
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (accept) state_nxt = (cmd_beats == 16'd0) ? S_DONE : S_CALC;
            S_CALC:   if (outstanding < OUT_MAX) state_nxt = S_ADDR;
            S_ADDR:   if (aw_hs) state_nxt = (remaining != {7'd0, beats_q}) ? S_CALC : S_WAIT_B;
            // Looking at the next count lets done follow the final B by one cycle.
            S_WAIT_B: if (outstanding_nxt == 4'd0) state_nxt = S_DONE;
            S_DONE:   state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge m00_axi_aclk or negedge m00_axi_aresetn) begin
        if (!m00_axi_aresetn) begin
            state       <= S_IDLE;
            addr_q      <= '0;
            remaining   <= '0;
            awaddr_q    <= '0;
            awlen_q     <= '0;
            beats_q     <= '0;
            outstanding <= '0;
            err_q       <= 1'b0;
            live_q      <= 1'b0;
        end else begin
            state       <= state_nxt;
            outstanding <= outstanding_nxt;
            live_q      <= 1'b1;
            if (accept) begin
                addr_q    <= cmd_addr & ADDR_MASK;
                remaining <= cmd_beats;
            end else if (aw_hs) begin
                addr_q    <= addr_q + step;
                remaining <= remaining - {7'd0, beats_q};
            end
            if (state == S_CALC) begin
                awaddr_q <= addr_q;
                awlen_q  <= 8'(beats_calc - 17'd1);
                beats_q  <= beats_calc[8:0];
            end
            if (b_bad)
                err_q <= 1'b1;
            else if (accept)
                err_q <= 1'b0;
        end
    end

    // live_q keeps the handshake outputs low while reset is held.
    assign cmd_ready = (state == S_IDLE) && live_q;
    assign busy      = (state == S_CALC) || (state == S_ADDR) || (state == S_WAIT_B);
    assign done      = (state == S_DONE);
    assign err       = err_q;
    assign bst_issue = aw_hs;
    assign bst_len   = awlen_q;

    assign m00_axi.m00_axi_awaddr  = awaddr_q;
    assign m00_axi.m00_axi_awlen   = awlen_q;
    assign m00_axi.m00_axi_awsize  = 3'(SZ);
    assign m00_axi.m00_axi_awburst = 2'b01;
    assign m00_axi.m00_axi_awvalid = (state == S_ADDR);
    assign m00_axi.m00_axi_bready  = live_q;
endmodule

// File: tb/tb_axi_wr_burst_sched.sv
// tb/tb_axi_wr_burst_sched.sv - randomized bench for axi_wr_burst_sched against a burst-list model

module tb_axi_wr_burst_sched;
    localparam int AW   = 32;
    localparam int BL   = 16;
    localparam int MAXO = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid, cmd_ready;
    logic [31:0] cmd_addr;
    logic [15:0] cmd_beats;
    logic        busy, done, err, bst_issue;
    logic [7:0]  bst_len;

    axi_wr_burst_sched_if #(.ADDR_WIDTH(AW)) axi ();

    axi_wr_burst_sched #(
        .C_AXI_ADDR_WIDTH(AW), .C_AXI_DATA_WIDTH(32),
        .C_AXI_BURST_LEN(BL), .C_MAX_OUTSTANDING(MAXO)
    ) dut (
        .m00_axi_aclk(clk), .m00_axi_aresetn(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr), .cmd_beats(cmd_beats),
        .busy(busy), .done(done), .err(err), .bst_issue(bst_issue), .bst_len(bst_len),
        .m00_axi(axi)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    logic [31:0] exp_addr[$];
    int          exp_len[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference burst list: walk the command a burst at a time with plain arithmetic.
    task automatic plan_bursts(input logic [31:0] addr, input int beats);
        logic [31:0] a;
        int r, page, b;
        exp_addr.delete();
        exp_len.delete();
        a = addr & 32'hFFFF_FFFC;
        r = beats;
        while (r > 0) begin
            page = (4096 - int'(a[11:0])) / 4;
            b = r;
            if (b > BL) b = BL;
            if (b > page) b = page;
            exp_addr.push_back(a);
            exp_len.push_back(b - 1);
            a = a + 32'(b * 4);
            r -= b;
        end
    endtask

    task automatic start_cmd(input logic [31:0] addr, input int beats, output bit ok);
        int cyc;
        ok = 1'b0;
        cmd_addr  = addr;
        cmd_beats = 16'(beats);
        cmd_valid = 1'b1;
        for (cyc = 0; cyc < 200 && !ok; cyc++) begin
            #1;
            if (cmd_ready) ok = 1'b1;
            tick();
        end
        cmd_valid = 1'b0;
        if (!ok) check("accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic run_cmd(input logic [31:0] addr, input int beats, input int bad_idx,
                           input int hold, input int ready_pct);
        int aw_n, b_n, nb, max_out, k;
        bit want_done, finished, ok;
        logic exp_err;
        int b_due[$];
        logic [1:0] b_rsp[$];
        plan_bursts(addr, beats);
        nb = exp_addr.size();
        exp_err = (bad_idx >= 0) && (bad_idx < nb);
        start_cmd(addr, beats, ok);
        if (!ok) return;
        want_done = (nb == 0);
        aw_n = 0; b_n = 0; max_out = 0; finished = 1'b0;
        for (k = 1; k <= 3000 && !finished; k++) begin
            axi.m00_axi_awready = ($urandom_range(99) < 32'(ready_pct));
            if (b_rsp.size() > 0 && k > hold && b_due[0] <= k) begin
                axi.m00_axi_bvalid = 1'b1;
                axi.m00_axi_bresp  = b_rsp[0];
            end else begin
                axi.m00_axi_bvalid = 1'b0;
                axi.m00_axi_bresp  = 2'b00;
            end
            #1;
            if (k == 1) begin
                check("busy_after_accept", 32'(busy), 32'(nb > 0));
                check("err_cleared_on_accept", 32'(err), 32'd0);
                check("awvalid_in_calc", 32'(axi.m00_axi_awvalid), 32'd0);
            end
            if (k == 2 && nb > 0) check("awvalid_latency", 32'(axi.m00_axi_awvalid), 32'd1);
            if (hold > 0 && k == hold) check("aw_count_while_b_held", 32'(aw_n), 32'((nb < MAXO) ? nb : MAXO));
            if (done || want_done) begin
                check("done_timing", 32'(done), 32'(want_done));
                if (want_done) begin
                    check("err_at_done", 32'(err), 32'(exp_err));
                    check("aw_total", 32'(aw_n), 32'(nb));
                end
                finished = 1'b1;
            end else begin
                if (axi.m00_axi_awvalid && axi.m00_axi_awready) begin
                    if (aw_n < nb) begin
                        check("awaddr", axi.m00_axi_awaddr, exp_addr[aw_n]);
                        check("awlen", 32'(axi.m00_axi_awlen), 32'(exp_len[aw_n]));
                        check("bst_issue", 32'(bst_issue), 32'd1);
                        check("bst_len", 32'(bst_len), 32'(exp_len[aw_n]));
                    end else begin
                        check("extra_aw", 32'(aw_n), 32'(nb));
                    end
                    b_due.push_back(k + 1 + int'($urandom_range(3)));
                    b_rsp.push_back((aw_n == bad_idx) ? 2'b10 : 2'b00);
                    aw_n++;
                end
                if (axi.m00_axi_bvalid && axi.m00_axi_bready) begin
                    void'(b_due.pop_front());
                    void'(b_rsp.pop_front());
                    b_n++;
                    if (b_n == nb) want_done = 1'b1;
                end
                if (aw_n - b_n > max_out) max_out = aw_n - b_n;
                tick();
            end
        end
        if (!finished) check("cmd_timeout", 32'd0, 32'd1);
        check("outstanding_bound", 32'(max_out <= MAXO), 32'd1);
        axi.m00_axi_awready = 1'b0;
        axi.m00_axi_bvalid  = 1'b0;
        axi.m00_axi_bresp   = 2'b00;
        tick();
        tick();
    endtask

    initial begin
        bit ok;
        cmd_valid = 1'b0; cmd_addr = '0; cmd_beats = '0;
        axi.m00_axi_awready = 1'b0; axi.m00_axi_bvalid = 1'b0; axi.m00_axi_bresp = 2'b00;
        tick(); tick();
        #1;
        check("rst_awvalid", 32'(axi.m00_axi_awvalid), 32'd0);
        check("rst_cmd_ready", 32'(cmd_ready), 32'd0);
        check("rst_bready", 32'(axi.m00_axi_bready), 32'd0);
        check("rst_status", {29'd0, busy, done, err}, 32'd0);
        check("rst_awaddr", axi.m00_axi_awaddr, 32'd0);
        check("rst_awlen", 32'(axi.m00_axi_awlen), 32'd0);
        check("awsize", 32'(axi.m00_axi_awsize), 32'd2);
        check("awburst", 32'(axi.m00_axi_awburst), 32'd1);
        tick();
        rst_n = 1'b1;
        tick();
        check("post_rst_bready", 32'(axi.m00_axi_bready), 32'd1);
        check("post_rst_cmd_ready", 32'(cmd_ready), 32'd1);

        run_cmd(32'h4000_0000, 16, -1, 0, 100);
        run_cmd(32'h4000_0FF0, 8, -1, 0, 100);
        run_cmd(32'h4000_0000, 40, -1, 0, 70);
        run_cmd(32'h4000_0000, 48, -1, 30, 100);
        run_cmd(32'h4000_0000, 48, 1, 0, 100);
        run_cmd(32'h1000_0000, 4, -1, 0, 100);
        run_cmd(32'h2000_0003, 0, -1, 0, 100);
        run_cmd(32'hFFFF_FFF0, 8, -1, 0, 100);

        axi.m00_axi_bvalid = 1'b1;
        tick();
        axi.m00_axi_bvalid = 1'b0;
        #1;
        check("unexpected_b_err", 32'(err), 32'd1);
        tick();
        run_cmd(32'h3000_0100, 20, -1, 0, 100);

        plan_bursts(32'h5000_0000, 48);
        start_cmd(32'h5000_0000, 48, ok);
        for (int i = 0; i < 5 && !axi.m00_axi_awvalid; i++) tick();
        #1;
        check("awvalid_before_reset", 32'(axi.m00_axi_awvalid), 32'd1);
        rst_n = 1'b0;
        #1;
        check("awvalid_drops_on_reset", 32'(axi.m00_axi_awvalid), 32'd0);
        check("busy_drops_on_reset", 32'(busy), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        check("cmd_ready_after_reset", 32'(cmd_ready), 32'd1);
        run_cmd(32'h5000_0000, 48, -1, 30, 100);

        for (int t = 0; t < 24; t++) begin
            logic [31:0] a;
            int beats, bad;
            a = $urandom;
            if ($urandom_range(1) == 1) a = (a & 32'hFFFF_F000) | 32'(12'hFFF - 12'($urandom_range(160)));
            beats = int'($urandom_range(70));
            bad = ($urandom_range(3) == 0) ? int'($urandom_range(4)) : -1;
            run_cmd(a, beats, bad, 0, int'($urandom_range(100, 40)));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
